// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// FSM states, parity/stop encodings, parity and stop-length functions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_RSVD
  } parity_t;

  typedef enum logic [1:0] {
    STOP_1,
    STOP_1P5,
    STOP_2,
    STOP_2B
  } stop_t;

  // XOR of the low (nbits+5) bits; inverted for odd parity.
  function automatic logic par_calc(
    input logic [7:0] data,
    input logic [1:0] nbits,
    input parity_t    mode
  );
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i <= int'(nbits) + 4) p = p ^ data[i];
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

  function automatic int stop_ticks(
    input stop_t sel,
    input int    ovs
  );
    int r;
    unique case (sel)
      STOP_1:   r = ovs;
      STOP_1P5: r = (3 * ovs) / 2;
      default:  r = 2 * ovs;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// UART transmitter: 5-8 data bits, none/even/odd parity, 1/1.5/2 stop, CTS, break.
// Ports: clk, reset(n), s_tick, din, tx_start, cfg, cts_en/cts_n, brk -> tx_ready, tx_done_tick, tx.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int OVS   = 16,
  parameter int DIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic [DIN_W-1:0] din,
  input  logic             tx_start,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity,
  input  logic [1:0]       stop_sel,
  input  logic             cts_en,
  input  logic             cts_n,
  input  logic             brk,
  output logic             tx_ready,
  output logic             tx_done_tick,
  output logic             tx
);

  localparam int SW = $clog2(2 * OVS);

  tx_state_t        state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [2:0]       n_q, n_d;
  logic [DIN_W-1:0] b_q, b_d;
  logic [1:0]       nd_q, nd_d;
  parity_t          par_q, par_d;
  logic             pbit_q, pbit_d;
  stop_t            stop_q, stop_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             alive_q;

  logic [SW-1:0] bit_lim;
  logic [SW-1:0] stop_lim;
  logic [2:0]    ndm1;
  logic          has_par;
  logic          s_last;

  assign bit_lim  = SW'(OVS - 1);
  assign stop_lim = SW'(stop_ticks(stop_q, OVS) - 1);
  assign ndm1     = 3'(nd_q) + 3'd4;
  assign has_par  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign s_last   = (s_q == bit_lim);

  // alive_q holds ready low for the whole reset period.
  assign tx_ready = alive_q & (state_q == ST_IDLE) & ~brk
                  & ~(cts_en & cts_n);

  assign tx           = tx_q;
  assign tx_done_tick = done_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    nd_d    = nd_q;
    par_d   = par_q;
    pbit_d  = pbit_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_d  = '0;
        n_d  = '0;
        tx_d = 1'b1;
        if (brk) begin
          state_d = ST_BREAK;
          tx_d    = 1'b0;
        end else if (tx_start && tx_ready) begin
          state_d = ST_START;
          b_d     = din;
          nd_d    = data_bits;
          par_d   = parity_t'(parity);
          stop_d  = stop_t'(stop_sel);
          pbit_d  = par_calc(din, data_bits, parity_t'(parity));
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_last) begin
            state_d = ST_DATA;
            s_d     = '0;
            n_d     = '0;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_last) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == ndm1) begin
              if (has_par) begin
                state_d = ST_PARITY;
                tx_d    = pbit_q;
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              n_d  = n_q + 3'd1;
              tx_d = b_q[1];
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_last) begin
            state_d = ST_STOP;
            s_d     = '0;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == stop_lim) begin
            state_d = ST_IDLE;
            s_d     = '0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        tx_d = 1'b0;
        if (!brk) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      nd_q    <= '0;
      par_q   <= PAR_NONE;
      pbit_q  <= 1'b0;
      stop_q  <= STOP_1;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      nd_q    <= nd_d;
      par_q   <= par_d;
      pbit_q  <= pbit_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      alive_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg.
// Stimulus pushes expected frames; a line monitor pops and checks them.
module tb_uart_tx_cfg;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic [7:0] din = '0;
  logic       tx_start = 1'b0;
  logic [1:0] data_bits = 2'd3;
  logic [1:0] parity = 2'd0;
  logic [1:0] stop_sel = 2'd0;
  logic       cts_en = 1'b0;
  logic       cts_n = 1'b0;
  logic       brk = 1'b0;
  logic       tx_ready;
  logic       tx_done_tick;
  logic       tx;

  uart_tx_cfg #(.OVS(OVS), .DIN_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .s_tick(s_tick),
    .din(din),
    .tx_start(tx_start),
    .data_bits(data_bits),
    .parity(parity),
    .stop_sel(stop_sel),
    .cts_en(cts_en),
    .cts_n(cts_n),
    .brk(brk),
    .tx_ready(tx_ready),
    .tx_done_tick(tx_done_tick),
    .tx(tx)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c = (c + 1) % 4;
      s_tick = (c == 0);
    end
  end

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          total;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;
  int   done_cnt = 0;
  int   mon_t = 0;
  bit   mon_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  // Line monitor: frame starts on a falling tx outside break.
  initial begin
    logic prev_tx;
    exp_t cur;
    int   k;
    prev_tx = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        mon_busy = 1'b0;
        prev_tx  = tx;
        continue;
      end
      if (tx_done_tick) done_cnt++;
      if (!mon_busy) begin
        if (prev_tx && !tx && !brk) begin
          if (sb.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            cur      = sb.pop_front();
            mon_busy = 1'b1;
            mon_t    = 0;
          end
        end
      end else begin
        if (s_tick) mon_t++;
        k = mon_t / OVS;
        if (s_tick && mon_t == cur.total) begin
          chk("done_at_end", tx_done_tick, 1);
          chk("stop_at_end", tx, 1);
          mon_busy = 1'b0;
        end else begin
          if (tx_done_tick) chk("early_done", 1, 0);
          if (s_tick && k < cur.nbits && (mon_t % OVS) == OVS / 2)
            chk($sformatf("bit%0d", k), tx, cur.bits[k]);
          else if (s_tick && k >= cur.nbits)
            chk("stop_level", tx, 1);
        end
      end
      prev_tx = tx;
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] db,
                      input logic [1:0] pr, input logic [1:0] sp,
                      input logic [15:0] bits, input int nb,
                      input int tot);
    exp_t e;
    @(negedge clk);
    chk("ready_before_send", tx_ready, 1);
    e.bits  = bits;
    e.nbits = nb;
    e.total = tot;
    sb.push_back(e);
    din       = d;
    data_bits = db;
    parity    = pr;
    stop_sel  = sp;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start  = 1'b0;
    din       = 8'hFF;
    data_bits = 2'd0;
    parity    = 2'd2;
    stop_sel  = 2'd2;
  endtask

  task automatic wait_done(input string nm);
    int start;
    bit got;
    start = done_cnt;
    got   = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (done_cnt > start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_done", tx_done_tick, 0);
    chk("rst_ready", tx_ready, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_rst", tx_ready, 1);

    // 8N1 0xA5
    send(8'hA5, 2'd3, 2'd0, 2'd0, 16'h014A, 9, 160);
    wait_done("t1");

    // 7E1 0x41, then 5O2 0x1F
    send(8'h41, 2'd2, 2'd1, 2'd0, 16'h0082, 9, 160);
    wait_done("t2a");
    send(8'h1F, 2'd0, 2'd2, 2'd2, 16'h003E, 7, 144);
    wait_done("t2b");

    // 8N1.5 0x00 with a stray request mid-frame
    send(8'h00, 2'd3, 2'd0, 2'd1, 16'h0000, 9, 168);
    repeat (100) @(negedge clk);
    chk("busy_not_ready", tx_ready, 0);
    din      = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done("t3");

    // CTS gating
    cts_en    = 1'b1;
    cts_n     = 1'b1;
    din       = 8'h5A;
    data_bits = 2'd3;
    parity    = 2'd0;
    stop_sel  = 2'd0;
    tx_start  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 0) begin
        chk("cts_block_ready", tx_ready, 0);
        chk("cts_block_tx", tx, 1);
      end
    end
    begin
      exp_t e;
      e.bits  = 16'h00B4;
      e.nbits = 9;
      e.total = 160;
      sb.push_back(e);
    end
    cts_n = 1'b0;
    @(negedge clk);
    chk("cts_started", tx, 0);
    tx_start = 1'b0;
    repeat (80) @(negedge clk);
    cts_n = 1'b1;
    wait_done("t4");
    chk("cts_idle_blocked", tx_ready, 0);
    cts_en = 1'b0;
    cts_n  = 1'b0;
    #1;
    chk("cts_released", tx_ready, 1);

    // Break, with a simultaneous request that must be dropped
    d0 = done_cnt;
    @(negedge clk);
    brk      = 1'b1;
    tx_start = 1'b1;
    #1;
    chk("brk_ready", tx_ready, 0);
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      if (i % 8 == 0) begin
        chk("brk_tx", tx, 0);
        chk("brk_ready_hold", tx_ready, 0);
      end
    end
    brk = 1'b0;
    @(negedge clk);
    chk("brk_rel_tx", tx, 1);
    chk("brk_rel_ready", tx_ready, 1);
    chk("brk_no_done", done_cnt, d0);

    // Reset during data bit 3, then a fresh frame
    d0 = done_cnt;
    send(8'hFF, 2'd3, 2'd0, 2'd0, 16'h01FE, 9, 160);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (mon_busy && mon_t >= 4 * OVS + 4) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) chk("bit3_timeout", 0, 1);
    end
    reset = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_ready", tx_ready, 0);
    chk("abort_done", tx_done_tick, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    send(8'h3C, 2'd3, 2'd0, 2'd0, 16'h0078, 9, 160);
    wait_done("t6");

    chk("sb_empty", sb.size(), 0);
    chk("done_count", done_cnt, 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Next-generation UART transmitter.
- Serialises one character per request with runtime-selectable data length (5–8), parity (none/even/odd) and stop length (1/1.5/2), plus CTS flow control and break generation.
- Driven by the shared external baud tick generator (s_tick, OVS ticks per bit). Sits between the io_core UART register interface and the tx pin.
- No internal queuing: a FIFO, if present, lives upstream and uses tx_ready as its pop enable.

Parameters:
- OVS, 16, s_ticks per bit period; must be even, 8..32.
- DIN_W, 8, width of din; fixed at 8 in this generation (5–8 bits selected at runtime).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low (reset=0 asserts).
- s_tick  in  1  baud oversample tick, one clk wide.
- din  in  DIN_W  character, LSB transmitted first.
- tx_start  in  1  request; accepted only when tx_ready=1.
- data_bits  in  2  0=5, 1=6, 2=7, 3=8 bits.
- parity  in  2  0=none, 1=even, 2=odd, 3=reserved (treated as none).
- stop_sel  in  2  0=1 bit, 1=1.5 bits, 2/3=2 bits.
- cts_en  in  1  enable flow control.
- cts_n  in  1  clear-to-send, active-low; already synchronised upstream.
- brk  in  1  break request.
- tx_ready  out  1  idle and able to accept.
- tx_done_tick  out  1  one-clk pulse at frame end.
- tx  out  1  serial line, registered.

Behaviour:
Reset (async, reset=0):
- state=IDLE, all counters 0, tx=1, tx_done_tick=0.
- tx_ready=0 while reset is low, and 1 after release.
- Reset mid-frame aborts the frame immediately, with no done pulse.

States: IDLE, START, DATA, PARITY, STOP, BREAK.

tx_ready:
- tx_ready = (state==IDLE) & ~brk & ~(cts_en & cts_n). Combinational from registers and inputs.

Acceptance (in IDLE):
- Acceptance = tx_start & tx_ready.
- On the accepting edge:
  - latch din, data_bits, parity and stop_sel;
  - state→START, tick counter s=0, tx register←0.
- Config changes mid-frame have no effect.
- tx_start when not ready is dropped, not queued.

Bit timing:
- Every bit lasts exactly OVS s_ticks; s counts s_ticks.
- An s_tick on the accepting edge itself is not counted.

Per-state transitions:
- START: on s_tick with s==OVS-1 → DATA, s=0, n=0, tx←b[0].
- DATA:
  - on s_tick with s==OVS-1, shift b right and compare n to ndata-1;
  - if n==ndata-1 → PARITY (parity≠none) or STOP;
  - else n++ and tx←next bit.
- PARITY:
  - tx = XOR of the ndata low bits of the latched char (even), or its inverse (odd);
  - after OVS ticks → STOP.
- STOP:
  - tx=1 for OVS, 3*OVS/2 or 2*OVS ticks per stop_sel;
  - on the last tick → IDLE and tx_done_tick=1 for exactly one clk (the cycle after that edge).

Flow control:
- cts_n is sampled only in IDLE.
- Deassertion mid-frame never truncates the frame.

BREAK:
- brk=1 in IDLE → BREAK; tx←0 while brk=1.
- brk falling → IDLE, tx←1.
- No done pulse.
- brk during a frame is ignored until IDLE.
- brk and tx_start in the same IDLE cycle: brk wins and the request is dropped (tx_ready=0).

Counter widths:
- s: $clog2(2*OVS) bits.
- n: 3 bits.
- No wrap-around: all terminal compares are equality on the latched limits.

Output registration:
- tx is always driven from a register; no combinational path from inputs.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum;
  - parity_t enum {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD};
  - stop_t enum;
  - function par_calc(data, nbits, mode);
  - function stop_ticks(stop_sel, OVS).
- A single module; no sub-module is warranted. The baud tick generator remains a separate existing block.

Test Plan:
1. 8N1, OVS=16, din=0xA5 → tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 16 ticks; tx_done_tick pulses once, 160 ticks after acceptance.
2. 7E1, din=0x41 → 7 data bits 1,0,0,0,0,0,1, parity bit 0, 1 stop; frame 160 ticks. 5O2, din=0x1F → data 1,1,1,1,1, parity 0, stop 32 ticks; frame 144 ticks.
3. 8N1.5, din=0x00 → stop high for 24 ticks; done 168 ticks after acceptance. A tx_start pulsed mid-frame is ignored: exactly one frame is sent.
4. cts_en=1, cts_n=1, tx_start held → tx_ready=0, tx stays 1. cts_n→0 → frame starts on that edge. cts_n→1 mid-frame → frame completes intact.
5. brk=1 for 50 clk in IDLE → tx=0 throughout, tx_ready=0, no done pulse. Release → tx=1, tx_ready=1.
6. reset=0 asserted during DATA bit 3 → tx=1 asynchronously, no done pulse. After release, a new 8N1 frame with 0x3C transmits correctly.
